// File: rtl/br_update_sched.sv
// Branch-resolution update scheduler: buffers up to two committed branches per
// cycle in an in-order FIFO and feeds the predictor's single update port.
module br_update_sched #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cmt_valid,
  input  logic [31:0]      cmt_pc0,
  input  logic [31:0]      cmt_pc1,
  input  logic [1:0]       cmt_taken,
  input  logic [1:0]       cmt_mispred,
  input  logic             drain_req,
  input  logic             stat_clr,
  output logic             stall_commit,
  output logic             drained,
  output logic [31:0]      pc_result,
  output logic             br_result,
  output logic             pc_result_load,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] STALL_TH = (AW+1)'(DEPTH - 2);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] tail_lane1;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          acc0;
  logic          acc1;
  logic          pop;
  logic [1:0]    n_acc;
  logic [1:0]    n_mis;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(inc);
    sat_add = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  // Stall whenever two free slots cannot be guaranteed, or a drain is in progress
  always_comb begin
    stall_commit = (count > STALL_TH) || (state != ST_RUN);
    acc0         = cmt_valid[0] & ~stall_commit;
    acc1         = cmt_valid[1] & ~stall_commit;
    n_acc        = {1'b0, acc0} + {1'b0, acc1};
    n_mis        = {1'b0, acc0 & cmt_mispred[0]} + {1'b0, acc1 & cmt_mispred[1]};
    tail_lane1   = tail + AW'(acc0);
    pop          = (count != '0) && (state != ST_DONE);
  end

  always_comb begin
    pc_result_load = pop;
    pc_result      = '0;
    br_result      = 1'b0;
    if (count != '0) begin
      pc_result = mem[head][32:1];
      br_result = mem[head][0];
    end
    drained = (state == ST_DONE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (drain_req) state_nxt = ST_DRAIN;
      ST_DRAIN: if ((count == '0) || ((count == (AW+1)'(1)) && pop)) state_nxt = ST_DONE;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Storage carries no reset; validity is tracked entirely by count/head/tail
  always_ff @(posedge clk) begin
    if (acc0) mem[tail]       <= {cmt_pc0, cmt_taken[0]};
    if (acc1) mem[tail_lane1] <= {cmt_pc1, cmt_taken[1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      state       <= ST_RUN;
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else begin
      head  <= head + AW'(pop);
      tail  <= tail + AW'(n_acc);
      count <= count + (AW+1)'(n_acc) - (AW+1)'(pop);
      state <= state_nxt;
      if (stat_clr) begin
        br_cnt      <= '0;
        mispred_cnt <= '0;
      end else begin
        br_cnt      <= sat_add(br_cnt, n_acc);
        mispred_cnt <= sat_add(mispred_cnt, n_mis);
      end
    end
  end

endmodule

// File: doc/br_update_sched.md
Name: br_update_sched

Overview:
- Schedules branch-resolution updates from the ROB commit stage into the branch predictor's single update port (pc_result / br_result / pc_result_load).
- The ROB can commit up to two resolved branches per cycle. The predictor accepts one update per cycle, so this block buffers updates in an in-order FIFO and drains one per cycle.
- Also applies commit backpressure, handles drain requests before fences/exceptions, and keeps branch/mispredict statistics.

Parameters:
- DEPTH, 8, FIFO entries (power of 2, ≥4)
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- cmt_valid  in  2  lane i commits a resolved branch this cycle
- cmt_pc0  in  32  PC of lane-0 branch
- cmt_pc1  in  32  PC of lane-1 branch
- cmt_taken  in  2  resolved direction per lane (1 = taken)
- cmt_mispred  in  2  lane i branch was mispredicted
- drain_req  in  1  ROB requests all pending updates be applied
- stat_clr  in  1  synchronous clear of statistics counters
- stall_commit  out  1  ROB must not present branch commits this cycle
- drained  out  1  one-cycle pulse: drain complete
- pc_result  out  32  PC of update presented to predictor
- br_result  out  1  taken bit of presented update
- pc_result_load  out  1  update valid; predictor consumes it this cycle
- br_cnt  out  CNT_W  accepted branches (saturating)
- mispred_cnt  out  CNT_W  accepted mispredicts (saturating)

Behaviour:
- FIFO and occupancy
  - FIFO entries are {pc[31:0], taken}. Head and tail pointers wrap modulo DEPTH.
  - count ranges 0..DEPTH.
- Accept
  - A lane is accepted when cmt_valid[i] && !stall_commit.
  - Accepted lanes are enqueued compacted, lane 0 before lane 1. Lane 1 alone occupies a single slot.
  - Commits presented while stall_commit=1 are dropped: no enqueue, no count. This is a protocol violation by the ROB.
- Output
  - pc_result_load = (count≠0) && state≠DONE. pc_result and br_result are driven combinationally from the FIFO head.
  - When count=0, pc_result=0 and br_result=0.
  - The head pops on every cycle pc_result_load=1. The predictor never stalls.
- Latency
  - A branch accepted at edge N appears on pc_result_load in cycle N+1 if the FIFO was empty.
  - Otherwise it appears after all older entries, one per cycle.
  - There is no bypass from commit inputs to outputs.
- Same-cycle events
  - Enqueue and dequeue in the same cycle are legal.
  - count_next = count + accepted − popped.
- stall_commit is combinational:
  - 1 when (DEPTH − count) < 2 (guarantees room for two).
  - 1 in DRAIN or DONE.
  - 0 otherwise.
  - Full FIFO: stall_commit=1 and the pop continues. Overflow is impossible.
- FSM (reset state RUN)
  - RUN: if drain_req, go to DRAIN.
  - DRAIN: accepts no new commits.
    - Go to DONE when count=0, or when count=1 and a pop occurs this cycle.
    - If count=0 at entry, DRAIN is still occupied for one cycle.
  - DONE: drained=1 for exactly this cycle; next state RUN. drain_req is ignored in DONE; if still high in RUN, a new drain starts.
  - drain_req deasserting during DRAIN does not abort the drain.
- Statistics
  - br_cnt += number of accepted lanes (0/1/2).
  - mispred_cnt += accepted lanes with cmt_mispred set. cmt_mispred on a non-accepted lane is ignored.
  - Both counters saturate at all-ones; adding 2 at all-ones−1 yields all-ones.
  - stat_clr sets both counters to 0 and discards that cycle's increments.
- Reset (rst=0, asynchronous, any time including mid-drain)
  - FIFO emptied (pointers and count = 0); pending updates are lost.
  - State RUN; counters 0.
  - Outputs immediately: pc_result_load=0, pc_result=0, br_result=0, stall_commit=0, drained=0.
  - Operation resumes on the first rising edge after rst returns high.

Test Plan:
- After reset, single lane-0 commit pc=0x0000_0040 taken=1 at edge N → cycle N+1: pc_result_load=1, pc_result=0x40, br_result=1; cycle N+2: pc_result_load=0; br_cnt=1.
- Dual commit: lane0 pc=0x100 taken=0, lane1 pc=0x104 taken=1, both mispred → two consecutive updates 0x100/0 then 0x104/1; br_cnt=2, mispred_cnt=2.
- Backpressure: dual commits every cycle with DEPTH=8 → stall_commit rises when count=7. Presented-but-stalled commits are not enqueued. Output order is strictly FIFO with no loss of accepted entries; count never exceeds 8.
- Drain with 5 entries queued → stall_commit=1 throughout. Five updates are issued in 5 cycles, then drained pulses for 1 cycle, then RUN with stall_commit=0.
- Saturation: force br_cnt to 0xFFFE, then dual accept → 0xFFFF. stat_clr together with a commit → both counters 0.
- Assert rst low mid-drain with 3 entries queued → pc_result_load=0 immediately. After release: count 0, RUN, no stale update issued.
